sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO for the next generation of the design's buffering blocks. Adds the following beyond the existing dual-clock FIFO:
- non-power-of-two depth
- exact fill count
- half-full flag derived from the count
- programmable almost-full and almost-empty thresholds
- registered read data with a valid strobe
- sticky overflow and underflow error flags
Used wherever producer and consumer share one clock, so no pointer synchronisers or Gray coding are needed.

---
 rtl/sync_fifo_flags.sv | 95 +++++++++
 tb/tb_sync_fifo_flags.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, exact fill count, programmable
// almost-full/almost-empty thresholds, registered read data and sticky error flags.
module sync_fifo_flags #(
    parameter int D_SIZE = 8,
    parameter int A_SIZE = 8,
    parameter int DEPTH  = 2**A_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_inc,
    input  logic [D_SIZE-1:0] w_data,
    input  logic              r_inc,
    input  logic [A_SIZE:0]   af_thresh,
    input  logic [A_SIZE:0]   ae_thresh,
    input  logic              clr_err,
    output logic [D_SIZE-1:0] r_data,
    output logic              r_valid,
    output logic              w_full,
    output logic              r_empty,
    output logic              w_half_full,
    output logic              w_almost_full,
    output logic              r_almost_empty,
    output logic [A_SIZE:0]   w_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int                C_W       = A_SIZE + 1;
    localparam logic [A_SIZE-1:0] LAST_ADDR = A_SIZE'(DEPTH - 1);
    localparam logic [A_SIZE:0]   FULL_CNT  = C_W'(DEPTH);
    localparam logic [A_SIZE:0]   HALF_CNT  = C_W'(DEPTH / 2);

    if (DEPTH < 2 || DEPTH > 2**A_SIZE) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must satisfy 2 <= DEPTH <= 2**A_SIZE");
    end

    logic [D_SIZE-1:0] mem [DEPTH];
    logic [A_SIZE-1:0] w_addr;
    logic [A_SIZE-1:0] r_addr;
    logic [A_SIZE:0]   count;
    logic              wr_ok;
    logic              rd_ok;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [A_SIZE-1:0] addr_next(input logic [A_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + A_SIZE'(1);
    endfunction

    assign w_full         = (count == FULL_CNT);
    assign r_empty        = (count == '0);
    assign w_half_full    = (count >= HALF_CNT);
    assign w_almost_full  = (count >= af_thresh);
    assign r_almost_empty = (count <= ae_thresh);
    assign w_count        = count;

    assign wr_ok = w_inc & ~w_full;
    assign rd_ok = r_inc & ~r_empty;

    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[w_addr] <= w_data;
        end
    end

    // Registered read stage: data and its valid strobe leave together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_addr    <= '0;
            r_addr    <= '0;
            count     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_addr <= addr_next(w_addr);
            end
            if (rd_ok) begin
                r_addr <= addr_next(r_addr);
                r_data <= mem[r_addr];
            end
            r_valid <= rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + C_W'(1);
                2'b01:   count <= count - C_W'(1);
                default: count <= count;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow  <= (w_inc & w_full)  | (overflow  & ~clr_err);
            underflow <= (r_inc & r_empty) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags at DEPTH=6, A_SIZE=3, against a queue-based model.
module tb_sync_fifo_flags;

    localparam int DEPTH = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_inc = 1'b0;
    logic [7:0] w_data = '0;
    logic       r_inc = 1'b0;
    logic [3:0] af_thresh = 4'd4;
    logic [3:0] ae_thresh = 4'd1;
    logic       clr_err = 1'b0;
    logic [7:0] r_data;
    logic       r_valid, w_full, r_empty, w_half_full, w_almost_full, r_almost_empty;
    logic [3:0] w_count;
    logic       overflow, underflow;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    sync_fifo_flags #(.D_SIZE(8), .A_SIZE(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .w_inc(w_inc), .w_data(w_data), .r_inc(r_inc),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .r_data(r_data), .r_valid(r_valid), .w_full(w_full), .r_empty(r_empty),
        .w_half_full(w_half_full), .w_almost_full(w_almost_full),
        .r_almost_empty(r_almost_empty), .w_count(w_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock with the given requests; the model follows the FIFO rules directly.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                         input logic c, input logic rs);
        bit full, empty;
        w_inc = w; w_data = d; r_inc = r; clr_err = c; rst = rs;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        @(posedge clk);
        if (!rs) begin
            q.delete();
            m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_valid = r && !empty;
            if (m_valid) m_data = q.pop_front();
            if (w && !full) q.push_back(d);
            m_ovf = (w && full) || (m_ovf && !c);
            m_unf = (r && empty) || (m_unf && !c);
        end
        #1;
        w_inc = 1'b0; r_inc = 1'b0; clr_err = 1'b0; rst = 1'b1;
    endtask

    task automatic test_reset();
        af_thresh = 4'd4; ae_thresh = 4'd1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vectors++; if (w_full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", w_full); end
        vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", r_empty); end
        vectors++; if (w_half_full !== 1'b0) begin miscompares++; $display("FAIL rst_half: got %b want 0", w_half_full); end
        vectors++; if (w_count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", w_count); end
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", r_valid); end
        vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h want 00", r_data); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b%b want 00", overflow, underflow); end
        vectors++; if (w_almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_af: got %b want 0", w_almost_full); end
        vectors++; if (r_almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_ae: got %b want 1", r_almost_empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
            vectors++; if (int'(w_count) !== i + 1) begin miscompares++; $display("FAIL fill_count: got %0d want %0d", w_count, i + 1); end
            vectors++; if (w_half_full !== (i + 1 >= 3)) begin miscompares++; $display("FAIL fill_half: got %b at count %0d", w_half_full, i + 1); end
            vectors++; if (w_full !== (i + 1 == DEPTH)) begin miscompares++; $display("FAIL fill_full: got %b at count %0d", w_full, i + 1); end
            vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_ovf: got %b want 0", overflow); end
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid: got %b want 1", r_valid); end
            vectors++; if (r_data !== 8'h11 + 8'(i)) begin miscompares++; $display("FAIL drain_data: got %h want %h", r_data, 8'h11 + 8'(i)); end
            vectors++; if (int'(w_count) !== DEPTH - 1 - i) begin miscompares++; $display("FAIL drain_count: got %0d want %0d", w_count, DEPTH - 1 - i); end
        end
        vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", r_empty); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        vectors++; if (r_valid !== 1'b0 || r_data !== 8'h16) begin miscompares++; $display("FAIL drain_hold: got valid=%b data=%h want 0/16", r_valid, r_data); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL drain_unf: got %b want 1", underflow); end
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL drain_rej_valid: got %b want 0", r_valid); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL drain_clr: got %b want 0", underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            cycle(1'b1, d, 1'b0, 1'b0, 1'b1);
            vectors++; if (w_count !== 4'd1) begin miscompares++; $display("FAIL wrap_count_w: got %0d want 1", w_count); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            vectors++; if (r_valid !== 1'b1 || r_data !== d) begin miscompares++; $display("FAIL wrap_data: got valid=%b data=%h want 1/%h", r_valid, r_data, d); end
            vectors++; if (w_count !== 4'd0) begin miscompares++; $display("FAIL wrap_count_r: got %0d want 0", w_count); end
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] front;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        front = q[0];
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        vectors++; if (r_valid !== 1'b1 || r_data !== front) begin miscompares++; $display("FAIL simul_data: got valid=%b data=%h want 1/%h", r_valid, r_data, front); end
        vectors++; if (w_count !== 4'd5) begin miscompares++; $display("FAIL simul_count: got %0d want 5", w_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL simul_ovf: got %b want 1", overflow); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL simul_clr: got %b want 0", overflow); end
        while (q.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            vectors++; if (r_data !== m_data || r_data === 8'hEE) begin miscompares++; $display("FAIL simul_drain: got %h want %h", r_data, m_data); end
        end
        vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL simul_empty: got %b want 1", r_empty); end
    endtask

    task automatic test_thresholds();
        af_thresh = 4'd4; ae_thresh = 4'd1;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            vectors++; if (w_almost_full !== (i >= 4)) begin miscompares++; $display("FAIL thr_af: got %b at count %0d", w_almost_full, i); end
        end
        af_thresh = 4'd7; #1;
        vectors++; if (w_almost_full !== 1'b0) begin miscompares++; $display("FAIL thr_af_above: got %b want 0", w_almost_full); end
        af_thresh = 4'd6; ae_thresh = 4'd6; #1;
        vectors++; if (w_almost_full !== 1'b1 || r_almost_empty !== 1'b1) begin miscompares++; $display("FAIL thr_eq_depth: got af=%b ae=%b want 1/1", w_almost_full, r_almost_empty); end
        ae_thresh = 4'd5; #1;
        vectors++; if (r_almost_empty !== 1'b0) begin miscompares++; $display("FAIL thr_ae5: got %b want 0", r_almost_empty); end
        af_thresh = 4'd4; ae_thresh = 4'd1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            vectors++; if (r_almost_empty !== (i <= 1)) begin miscompares++; $display("FAIL thr_ae: got %b at count %0d", r_almost_empty, i); end
        end
        af_thresh = 4'd0; #1;
        vectors++; if (w_almost_full !== 1'b1) begin miscompares++; $display("FAIL thr_af_zero: got %b want 1", w_almost_full); end
        af_thresh = 4'd4;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", r_valid); end
        vectors++; if (r_empty !== 1'b1 || w_count !== 4'd0) begin miscompares++; $display("FAIL mid_level: got empty=%b count=%0d want 1/0", r_empty, w_count); end
        vectors++; if (w_half_full !== 1'b0 || w_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL mid_flags: got half=%b full=%b ovf=%b unf=%b want 0000", w_half_full, w_full, overflow, underflow); end
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        vectors++; if (r_valid !== 1'b1 || r_data !== 8'hA5) begin miscompares++; $display("FAIL mid_newdata: got valid=%b data=%h want 1/a5", r_valid, r_data); end
    endtask

    task automatic test_random();
        af_thresh = 4'($urandom_range(0, 7));
        ae_thresh = 4'($urandom_range(0, 7));
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) != 0));
            vectors++; if (r_valid !== m_valid || r_data !== m_data) begin miscompares++; $display("FAIL rand_read: got %b/%h want %b/%h", r_valid, r_data, m_valid, m_data); end
            vectors++; if (int'(w_count) !== q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", w_count, q.size()); end
            vectors++; if (w_full !== (q.size() == DEPTH) || r_empty !== (q.size() == 0) || w_half_full !== (q.size() >= DEPTH / 2)) begin miscompares++; $display("FAIL rand_level_flags: got f=%b e=%b h=%b at count %0d", w_full, r_empty, w_half_full, q.size()); end
            vectors++; if (w_almost_full !== (q.size() >= int'(af_thresh)) || r_almost_empty !== (q.size() <= int'(ae_thresh))) begin miscompares++; $display("FAIL rand_thresh: got af=%b ae=%b at count %0d", w_almost_full, r_almost_empty, q.size()); end
            vectors++; if (overflow !== m_ovf || underflow !== m_unf) begin miscompares++; $display("FAIL rand_err: got %b%b want %b%b", overflow, underflow, m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_simul();
        test_thresholds();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
